// File: rtl/hack_pkg.sv
// Shared types and image-format constants for the Hack ROM loader.
package hack_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int unsigned ROM_DEPTH_DEF = 1024;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned COUNT_W       = 16;

endpackage

// File: rtl/hack_rom.sv
// Instruction store: synchronous write port, asynchronous read port, no reset.
module hack_rom
  import hack_pkg::*;
#(
  parameter int unsigned DEPTH  = ROM_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Loads a length-prefixed, checksummed program image over a byte link into
// the instruction ROM, holding the CPU in reset until the image is accepted.
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int unsigned ADDR_W    = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  input  logic [14:0]       pc,
  output logic [WORD_W-1:0] instruction,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  state_t             state, state_next;
  logic [BYTE_W-1:0]  cnt_hi;
  logic [COUNT_W-1:0] count;
  logic [BYTE_W-1:0]  hi;
  logic [ADDR_W-1:0]  addr;
  logic [BYTE_W-1:0]  csum;

  logic               accept;
  logic [COUNT_W-1:0] hdr_n;
  logic               hdr_bad;
  logic               last_word;
  logic               rom_we;
  logic [WORD_W-1:0]  rom_rdata;
  logic               pc_in_range;

  assign accept    = byte_valid && byte_ready;
  assign hdr_n     = {cnt_hi, byte_in};
  assign hdr_bad   = (hdr_n == '0) || (32'(hdr_n) > ROM_DEPTH);
  // count is at least 1 whenever DAT_LO is reachable, so count-1 never wraps here
  assign last_word = (COUNT_W'(addr) == count - COUNT_W'(1));

  always_comb begin
    state_next = state;
    case (state)
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: if (accept) state_next = hdr_bad ? ERR : DAT_HI;
      DAT_HI: if (accept) state_next = DAT_LO;
      DAT_LO: if (accept) state_next = last_word ? CSUM : DAT_HI;
      CSUM:   if (accept) state_next = (byte_in == csum) ? RUN : ERR;
      RUN:    if (reload) state_next = HDR_HI;
      ERR:    state_next = ERR;
      default: state_next = HDR_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HDR_HI;
      cnt_hi  <= '0;
      count   <= '0;
      hi      <= '0;
      addr    <= '0;
      csum    <= '0;
      cpu_rst <= 1'b1;
    end else begin
      state   <= state_next;
      cpu_rst <= (state_next != RUN);
      case (state)
        HDR_HI: begin
          csum <= '0;
          if (accept) cnt_hi <= byte_in;
        end
        HDR_LO: if (accept) begin
          count <= hdr_n;
          addr  <= '0;
        end
        DAT_HI: if (accept) begin
          hi   <= byte_in;
          csum <= csum + byte_in;
        end
        DAT_LO: if (accept) begin
          addr <= addr + 1'b1;
          csum <= csum + byte_in;
        end
        RUN: if (reload) begin
          addr <= '0;
          csum <= '0;
        end
        default: ;
      endcase
    end
  end

  assign byte_ready = (state != RUN);
  assign load_done  = (state == RUN);
  assign load_err   = (state == ERR);
  assign rom_we     = (state == DAT_LO) && accept;

  hack_rom #(
    .DEPTH  (ROM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (addr),
    .wdata ({hi, byte_in}),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (rom_rdata)
  );

  assign pc_in_range = (32'(pc) < ROM_DEPTH);
  assign instruction = (load_done && pc_in_range) ? rom_rdata : '0;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed-vector bench for hack_rom_loader with hand-computed expectations.
module tb_hack_rom_loader;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        reload = 1'b0;
  logic [14:0] pc = '0;
  logic [15:0] instruction;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;

  hack_rom_loader #(.ROM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .reload      (reload),
    .pc          (pc),
    .instruction (instruction),
    .cpu_rst     (cpu_rst),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte after gap idle cycles and waits (bounded) for acceptance.
  task automatic put_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int w = 0; w < 20 && !byte_ready; w++) tick();
    check("byte_ready_wait", {15'b0, byte_ready}, 16'h0001);
    if (byte_ready) tick();
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic check_pc(input string tag, input logic [14:0] p, input logic [15:0] exp);
    pc = p;
    #1;
    check(tag, instruction, exp);
  endtask

  task automatic check_flags(input string tag, input logic ready, input logic crst,
                             input logic done, input logic err);
    check(tag, {12'b0, byte_ready, cpu_rst, load_done, load_err},
          {12'b0, ready, crst, done, err});
  endtask

  initial begin
    #7 rst = 1'b1;
    tick();
    check_flags("reset_flags", 1, 1, 0, 0);
    check_pc("reset_instr", 15'd0, 16'h0000);

    // N=2: 0005, EC10; data-byte sum 00+05+EC+10 = 8'h01
    put_byte(8'h00, 0); put_byte(8'h02, 0);
    check_flags("hdr_ok", 1, 1, 0, 0);
    put_byte(8'h00, 0); put_byte(8'h05, 0);
    put_byte(8'hEC, 0); put_byte(8'h10, 0);
    check_flags("pre_csum", 1, 1, 0, 0);
    put_byte(8'h01, 0);
    check_flags("run_flags", 0, 0, 1, 0);
    check_pc("run_pc0", 15'd0, 16'h0005);
    check_pc("run_pc1", 15'd1, 16'hEC10);
    check_pc("run_pc_depth", 15'(DEPTH), 16'h0000);

    // Reload with a coincident valid byte: that byte must not be taken as header
    byte_in = 8'h00; byte_valid = 1'b1; reload = 1'b1;
    tick();
    reload = 1'b0; byte_valid = 1'b0;
    check_flags("reload_flags", 1, 1, 0, 0);
    check_pc("reload_instr", 15'd0, 16'h0000);
    put_byte(8'h00, 0); put_byte(8'h02, 0);
    check_flags("reload_hdr", 1, 1, 0, 0);
    put_byte(8'h00, 0); put_byte(8'h05, 0);
    put_byte(8'hEC, 0); put_byte(8'h10, 0);
    put_byte(8'hFD, 0);
    check_flags("bad_csum", 1, 1, 0, 1);
    reload = 1'b1; tick(); tick(); reload = 1'b0;
    check_flags("err_sticky_reload", 1, 1, 0, 1);
    put_byte(8'h00, 0); put_byte(8'h01, 0); put_byte(8'h00, 0);
    check_flags("err_drain", 1, 1, 0, 1);
    check_pc("err_instr", 15'd0, 16'h0000);

    do_reset();
    check_flags("reset_from_err", 1, 1, 0, 0);
    put_byte(8'h00, 0);
    check_flags("n0_after_hi", 1, 1, 0, 0);
    put_byte(8'h00, 0);
    check_flags("n0_err", 1, 1, 0, 1);

    do_reset();
    put_byte(8'h04, 0); put_byte(8'h01, 0);
    check_flags("n_over_err", 1, 1, 0, 1);

    do_reset();
    put_byte(8'h04, 0); put_byte(8'h00, 0);
    check_flags("n_depth_ok", 1, 1, 0, 0);

    // Same good image with byte_valid gaps between every byte
    do_reset();
    put_byte(8'h00, 1); put_byte(8'h02, 1);
    put_byte(8'h00, 1); put_byte(8'h05, 1);
    put_byte(8'hEC, 1); put_byte(8'h10, 1);
    put_byte(8'h01, 1);
    check_flags("gap_run", 0, 0, 1, 0);
    check_pc("gap_pc0", 15'd0, 16'h0005);
    check_pc("gap_pc1", 15'd1, 16'hEC10);

    // Abandon a partial image, then load N=1 7FFF (sum 7F+FF = 8'h7E)
    do_reset();
    put_byte(8'h00, 0); put_byte(8'h02, 0);
    put_byte(8'h12, 0); put_byte(8'h34, 0); put_byte(8'h56, 0);
    do_reset();
    check_flags("midload_reset", 1, 1, 0, 0);
    put_byte(8'h00, 0); put_byte(8'h01, 0);
    put_byte(8'h7F, 0); put_byte(8'hFF, 0);
    put_byte(8'h7E, 0);
    check_flags("n1_run", 0, 0, 1, 0);
    check_pc("n1_pc0", 15'd0, 16'h7FFF);

    // Reload N=1 0000; word 1 keeps its earlier content
    pc = '0;
    reload = 1'b1; tick(); reload = 1'b0;
    check_flags("reload2", 1, 1, 0, 0);
    put_byte(8'h00, 0); put_byte(8'h01, 0); put_byte(8'h00, 0);
    check_flags("reload2_mid", 1, 1, 0, 0);
    put_byte(8'h00, 0); put_byte(8'h00, 0);
    check_flags("reload2_run", 0, 0, 1, 0);
    check_pc("reload2_pc0", 15'd0, 16'h0000);
    check_pc("reload2_pc1", 15'd1, 16'hEC10);
    check_pc("reload2_pc_depth", 15'(DEPTH), 16'h0000);
    check_pc("reload2_pc_max", 15'h7FFF, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
